// File: rtl/coil_switch_core_pkg.sv
// rtl/coil_switch_core_pkg.sv - shared CREG/EFLG bit indices and sequencer state codes
// Imported by coil_switch_core and its synchronizer sub-module.
package coil_switch_core_pkg;

    // CREG bit positions
    localparam int CREG_ARM       = 0;
    localparam int CREG_SRC       = 1;
    localparam int CREG_SOFT_FIRE = 2;
    localparam int CREG_CLR_FLG   = 3;

    // EFLG bit positions; [1:0] are live status, [7:2] are sticky
    localparam int EFLG_ARMED  = 0;
    localparam int EFLG_BUSY   = 1;
    localparam int EFLG_DONE   = 2;
    localparam int EFLG_LIMIT  = 3;
    localparam int EFLG_OCP    = 4;
    localparam int EFLG_RETRIG = 5;
    localparam int EFLG_ZLMT   = 6;
    localparam int EFLG_ABORT  = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_FIRE  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/coil_switch_core_sync_edge.sv
// rtl/coil_switch_core_sync_edge.sv - SYNC-stage synchronizer with optional registered rise detect
// Ports: clk, rst_n (async active-low), d (asynchronous input),
//        q (synchronized level when RISE=0, one-clock registered rising-edge pulse when RISE=1).
module coil_switch_core_sync_edge #(
    parameter int SYNC = 2,
    parameter bit RISE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC-1:0] sync_q;
    logic            level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], d};
        end
    end

    assign level = sync_q[SYNC-1];

    generate
        if (RISE) begin : g_rise
            logic prev_q;
            logic rise_q;
            // Registered edge: the pulse appears one clock after the synchronized level rises.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_q <= 1'b0;
                    rise_q <= 1'b0;
                end else begin
                    prev_q <= level;
                    rise_q <= level & ~prev_q;
                end
            end
            assign q = rise_q;
        end else begin : g_level
            assign q = level;
        end
    endgenerate

endmodule

// File: rtl/coil_switch_core.sv
// rtl/coil_switch_core.sv - coil shot sequencer: armed trigger, delay, bounded gate pulse, flags
// Ports: I_clk, I_rst_n (async active-low), I_creg (ARM/SRC/SOFT_FIRE/CLR_FLG),
//        I_dly/I_lmt (delay and gate limit, clocks), I_sensor/I_ocp (asynchronous),
//        O_gate (registered coil drive), O_eflg (status/sticky flags), O_acc (gate-on clocks).
module coil_switch_core
    import coil_switch_core_pkg::*;
#(
    parameter int W    = 24,
    parameter int SYNC = 2
) (
    input  logic         I_clk,
    input  logic         I_rst_n,
    input  logic [7:0]   I_creg,
    input  logic [W-1:0] I_dly,
    input  logic [W-1:0] I_lmt,
    input  logic         I_sensor,
    input  logic         I_ocp,
    output logic         O_gate,
    output logic [7:0]   O_eflg,
    output logic [W-1:0] O_acc
);

    state_t       state_q;
    logic [W-1:0] dly_q;
    logic [W-1:0] lmt_q;
    logic [W-1:0] cnt_q;
    logic [7:2]   flg_q;
    logic [7:2]   flg_set;

    logic sensor_rise;
    logic ocp_lvl;
    logic soft_prev_q;
    logic soft_rise_q;
    logic trig;
    logic arm;
    logic clr;
    logic busy;
    logic acc_last;
    logic [W-1:0] acc_inc;
    logic unused_creg_rsvd;

    coil_switch_core_sync_edge #(.SYNC(SYNC), .RISE(1'b1)) u_sensor_sync (
        .clk   (I_clk),
        .rst_n (I_rst_n),
        .d     (I_sensor),
        .q     (sensor_rise)
    );

    coil_switch_core_sync_edge #(.SYNC(SYNC), .RISE(1'b0)) u_ocp_sync (
        .clk   (I_clk),
        .rst_n (I_rst_n),
        .d     (I_ocp),
        .q     (ocp_lvl)
    );

    // Soft fire is already synchronous; only the registered edge detect is needed.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            soft_prev_q <= 1'b0;
            soft_rise_q <= 1'b0;
        end else begin
            soft_prev_q <= I_creg[CREG_SOFT_FIRE];
            soft_rise_q <= I_creg[CREG_SOFT_FIRE] & ~soft_prev_q;
        end
    end

    assign arm              = I_creg[CREG_ARM];
    assign clr              = I_creg[CREG_CLR_FLG];
    assign trig             = I_creg[CREG_SRC] ? soft_rise_q : sensor_rise;
    assign busy             = (state_q == ST_DELAY) || (state_q == ST_FIRE);
    assign acc_inc          = (&O_acc) ? O_acc : O_acc + W'(1);
    assign acc_last         = (O_acc == lmt_q - W'(1));
    assign unused_creg_rsvd = ^I_creg[7:4];

    // FSM and counters; OCP outranks disarm, which outranks trigger/count.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
            O_gate  <= 1'b0;
            O_acc   <= '0;
            cnt_q   <= '0;
            dly_q   <= '0;
            lmt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    O_gate <= 1'b0;
                    if (arm) state_q <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!arm) begin
                        state_q <= ST_IDLE;
                    end else if (trig) begin
                        // Snapshot so register writes during the shot have no effect.
                        dly_q <= I_dly;
                        lmt_q <= I_lmt;
                        O_acc <= '0;
                        cnt_q <= '0;
                        if (I_lmt == '0) begin
                            state_q <= ST_DONE;
                        end else if (I_dly == '0) begin
                            state_q <= ST_FIRE;
                            O_gate  <= 1'b1;
                        end else begin
                            state_q <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (ocp_lvl) begin
                        state_q <= ST_DONE;
                    end else if (!arm) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == dly_q - W'(1)) begin
                        state_q <= ST_FIRE;
                        O_gate  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + W'(1);
                    end
                end
                ST_FIRE: begin
                    // Every clock the gate was high counts, including the terminating one.
                    O_acc <= acc_inc;
                    if (ocp_lvl) begin
                        O_gate  <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (!arm) begin
                        O_gate  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (acc_last) begin
                        O_gate  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    O_gate <= 1'b0;
                    if (!arm) state_q <= ST_IDLE;
                end
                default: begin
                    O_gate  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        flg_set              = '0;
        flg_set[EFLG_DONE]   = (state_q == ST_DONE);
        flg_set[EFLG_LIMIT]  = (state_q == ST_FIRE) && !ocp_lvl && arm && acc_last;
        flg_set[EFLG_OCP]    = ocp_lvl;
        flg_set[EFLG_RETRIG] = trig && (busy || (state_q == ST_DONE));
        flg_set[EFLG_ZLMT]   = (state_q == ST_ARMED) && arm && trig && (I_lmt == '0);
        flg_set[EFLG_ABORT]  = busy && !ocp_lvl && !arm;
    end

    // Sticky flags: CLR_FLG is a level clear, and a set in the same clock wins.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            flg_q <= '0;
        end else begin
            flg_q <= (flg_q & ~{6{clr}}) | flg_set;
        end
    end

    assign O_eflg = {flg_q, busy, (state_q == ST_ARMED)};

endmodule

// File: tb/tb_coil_switch_core.sv
// tb/tb_coil_switch_core.sv - self-checking bench for coil_switch_core
module tb_coil_switch_core;

    localparam int W    = 24;
    localparam int SYNC = 2;

    logic         I_clk;
    logic         I_rst_n;
    logic [7:0]   I_creg;
    logic [W-1:0] I_dly;
    logic [W-1:0] I_lmt;
    logic         I_sensor;
    logic         I_ocp;
    logic         O_gate;
    logic [7:0]   O_eflg;
    logic [W-1:0] O_acc;

    int total = 0;
    int bad   = 0;

    coil_switch_core #(.W(W), .SYNC(SYNC)) dut (
        .I_clk    (I_clk),
        .I_rst_n  (I_rst_n),
        .I_creg   (I_creg),
        .I_dly    (I_dly),
        .I_lmt    (I_lmt),
        .I_sensor (I_sensor),
        .I_ocp    (I_ocp),
        .O_gate   (O_gate),
        .O_eflg   (O_eflg),
        .O_acc    (O_acc)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge I_clk);
            @(negedge I_clk);
        end
    endtask

    // Disarm, clear sticky flags, return to IDLE.
    task automatic prep();
        I_sensor = 1'b0;
        I_ocp    = 1'b0;
        I_creg   = 8'h00;
        tick(2);
        I_creg = 8'h08;
        tick(1);
        I_creg = 8'h00;
        tick(1);
    endtask

    task automatic arm_src(input bit src);
        I_creg = {6'b0, src, 1'b1};
        tick(2);
    endtask

    // Trigger edge to gate-edge reference: SYNC+1 clocks of trigger latency plus the state change.
    function automatic int trig_edge(input bit src);
        return src ? 2 : SYNC + 2;
    endfunction

    // Fire one shot and observe the gate for a window of clocks; mid-shot writes to DLY/LMT
    // after the snapshot edge and an optional second sensor pulse are injected.
    task automatic shoot(input bit src, input int window, input int retrig_at,
                         output int first, output int highs);
        int t;
        t     = trig_edge(src);
        first = -1;
        highs = 0;
        if (src) I_creg[2] = 1'b1;
        else I_sensor = 1'b1;
        for (int k = 1; k <= window; k++) begin
            tick(1);
            if (k == 3) begin
                I_sensor  = 1'b0;
                I_creg[2] = 1'b0;
            end
            if (k == t + 1) begin
                I_dly = W'($urandom_range(20, 0));
                I_lmt = W'($urandom_range(20, 0));
            end
            if (retrig_at > 0 && k == retrig_at) I_sensor = 1'b1;
            if (retrig_at > 0 && k == retrig_at + 3) I_sensor = 1'b0;
            if (O_gate === 1'b1) begin
                highs++;
                if (first < 0) first = k;
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if (O_gate !== 1'b0) begin bad++; $display("FAIL reset_gate got=%0h want=0", O_gate); end
        total++;
        if (O_eflg !== 8'h00) begin bad++; $display("FAIL reset_eflg got=%0h want=00", O_eflg); end
        total++;
        if (O_acc !== '0) begin bad++; $display("FAIL reset_acc got=%0d want=0", O_acc); end
    endtask

    // One shot checked against the reference: gate starts at trigger edge + dly,
    // stays high lmt clocks, acc = lmt, flags DONE|LIMIT or DONE|ZLMT.
    task automatic check_shot(input string name, input bit src, input int dly, input int lmt,
                              input int retrig_at);
        int first, highs, window, exp_first;
        logic [7:0] exp_flg;
        prep();
        I_dly = W'(dly);
        I_lmt = W'(lmt);
        arm_src(src);
        total++;
        if (O_eflg !== 8'h01) begin bad++; $display("FAIL %s_armed eflg got=%0h want=01", name, O_eflg); end
        window = trig_edge(src) + dly + lmt + 5;
        shoot(src, window, retrig_at, first, highs);
        exp_first = (lmt == 0) ? -1 : trig_edge(src) + dly;
        exp_flg   = (lmt == 0) ? 8'h44 : 8'h0C;
        if (retrig_at > 0) exp_flg = exp_flg | 8'h20;
        total++;
        if (first != exp_first) begin bad++; $display("FAIL %s_start got=%0d want=%0d (dly=%0d lmt=%0d)", name, first, exp_first, dly, lmt); end
        total++;
        if (highs != lmt) begin bad++; $display("FAIL %s_width got=%0d want=%0d", name, highs, lmt); end
        total++;
        if (O_acc !== W'(lmt)) begin bad++; $display("FAIL %s_acc got=%0d want=%0d", name, O_acc, lmt); end
        total++;
        if (O_eflg !== exp_flg) begin bad++; $display("FAIL %s_eflg got=%0h want=%0h", name, O_eflg, exp_flg); end
    endtask

    task automatic test_directed_shots();
        check_shot("sensor_d5_l10", 1'b0, 5, 10, 0);
        check_shot("soft_d0_l1", 1'b1, 0, 1, 0);
        check_shot("zero_lmt", 1'b1, 4, 0, 0);
        check_shot("mid_delay_write", 1'b1, 10, 4, 0);
    endtask

    task automatic test_random_shots();
        for (int n = 0; n < 12; n++) begin
            check_shot("random", 1'($urandom_range(1, 0)), int'($urandom_range(8, 0)),
                       int'($urandom_range(12, 0)), 0);
        end
    endtask

    task automatic test_retrig();
        check_shot("retrig", 1'b0, 2, 15, 9);
    endtask

    task automatic test_ocp();
        int highs, lowat;
        bit reached;
        prep();
        I_dly = W'(3);
        I_lmt = W'(100);
        arm_src(1'b1);
        I_creg[2] = 1'b1;
        highs   = 0;
        reached = 1'b0;
        for (int k = 1; k <= 60 && !reached; k++) begin
            tick(1);
            if (k == 3) I_creg[2] = 1'b0;
            if (O_gate === 1'b1) highs++;
            if (highs == 20) reached = 1'b1;
        end
        total++;
        if (!reached) begin bad++; $display("FAIL ocp_reach gate_clocks got=%0d want=20", highs); end
        I_ocp = 1'b1;
        lowat = -1;
        for (int j = 1; j <= 6; j++) begin
            tick(1);
            if (O_gate === 1'b0 && lowat < 0) lowat = j;
        end
        total++;
        if (lowat < 1 || lowat > SYNC + 1) begin bad++; $display("FAIL ocp_gate_off clocks got=%0d want<=%0d", lowat, SYNC + 1); end
        total++;
        if (O_eflg[4] !== 1'b1) begin bad++; $display("FAIL ocp_flag eflg got=%0h want bit4", O_eflg); end
        total++;
        if (O_acc < W'(20) || O_acc > W'(23)) begin bad++; $display("FAIL ocp_acc got=%0d want=20..23", O_acc); end
        I_ocp = 1'b0;
        tick(4);
        I_creg[3] = 1'b1;
        tick(1);
        I_creg[3] = 1'b0;
        tick(1);
        total++;
        if (O_eflg !== 8'h04) begin bad++; $display("FAIL ocp_clear eflg got=%0h want=04", O_eflg); end
    endtask

    task automatic test_abort();
        int highs;
        bit reached;
        prep();
        I_dly = W'(2);
        I_lmt = W'(50);
        arm_src(1'b1);
        I_creg[2] = 1'b1;
        highs   = 0;
        reached = 1'b0;
        for (int k = 1; k <= 40 && !reached; k++) begin
            tick(1);
            if (k == 3) I_creg[2] = 1'b0;
            if (O_gate === 1'b1) highs++;
            if (highs == 5) reached = 1'b1;
        end
        total++;
        if (!reached) begin bad++; $display("FAIL abort_reach gate_clocks got=%0d want=5", highs); end
        I_creg = 8'h02;
        tick(1);
        total++;
        if (O_gate !== 1'b0) begin bad++; $display("FAIL abort_gate got=%0h want=0", O_gate); end
        total++;
        if (O_eflg !== 8'h80) begin bad++; $display("FAIL abort_eflg got=%0h want=80", O_eflg); end
        total++;
        if (O_acc !== W'(highs)) begin bad++; $display("FAIL abort_acc got=%0d want=%0d", O_acc, highs); end
    endtask

    task automatic test_async_reset();
        bit reached;
        prep();
        I_dly = W'(1);
        I_lmt = W'(40);
        arm_src(1'b1);
        I_creg[2] = 1'b1;
        reached = 1'b0;
        for (int k = 1; k <= 20 && !reached; k++) begin
            tick(1);
            if (k == 3) I_creg[2] = 1'b0;
            if (O_gate === 1'b1) reached = 1'b1;
        end
        total++;
        if (!reached) begin bad++; $display("FAIL areset_reach gate got=0 want=1"); end
        tick(3);
        #2;
        I_rst_n = 1'b0;
        #1;
        total++;
        if (O_gate !== 1'b0) begin bad++; $display("FAIL areset_gate got=%0h want=0", O_gate); end
        total++;
        if (O_eflg !== 8'h00) begin bad++; $display("FAIL areset_eflg got=%0h want=00", O_eflg); end
        total++;
        if (O_acc !== '0) begin bad++; $display("FAIL areset_acc got=%0d want=0", O_acc); end
        I_creg = 8'h00;
        @(negedge I_clk);
        I_rst_n = 1'b1;
        tick(3);
        total++;
        if (O_gate !== 1'b0 || O_eflg !== 8'h00) begin bad++; $display("FAIL areset_after gate=%0h eflg=%0h want 0/00", O_gate, O_eflg); end
    endtask

    initial begin
        I_rst_n  = 1'b0;
        I_creg   = 8'h00;
        I_dly    = '0;
        I_lmt    = '0;
        I_sensor = 1'b0;
        I_ocp    = 1'b0;
        tick(3);
        test_reset();
        I_rst_n = 1'b1;
        tick(2);
        test_directed_shots();
        test_random_shots();
        test_retrig();
        test_ocp();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
